// File: rtl/display_scheduler_if.sv
// Handshake and display bus between the display scheduler and the blocks around it.
// The master drives key/error/clear requests; the slave (scheduler) drives the display.
interface display_scheduler_if;
    logic        key_valid;
    logic [7:0]  key_data;
    logic        key_ready;
    logic        err_valid;
    logic        clear;
    logic [31:0] NUMB;
    logic [7:0]  MASK;
    logic        ERROR;

    modport master (
        output key_valid, key_data, err_valid, clear,
        input  key_ready, NUMB, MASK, ERROR
    );

    modport slave (
        input  key_valid, key_data, err_valid, clear,
        output key_ready, NUMB, MASK, ERROR
    );
endinterface

// File: rtl/display_scheduler.sv
// Shares the 8-digit display between the scancode byte history and a timed,
// blinking error banner; all display outputs are registered.
module display_scheduler #(
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic         clk,
    input  logic         rst,
    display_scheduler_if.slave bus
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [31:0]         hist_reg, hist_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [HOLD_W-1:0]   hold_reg, hold_next;
    logic [BLINK_W-1:0]  blink_reg, blink_next;
    logic [31:0]         numb_reg, numb_next;
    logic [7:0]          mask_reg, mask_next;
    logic                error_reg, error_next;
    logic                key_ready;
    logic                accept;
    logic                banner_restart;
    logic [7:0]          show_mask;

    assign key_ready     = !rst && (state_reg != ERR);
    assign accept        = bus.key_valid && key_ready;
    assign bus.key_ready = key_ready;
    assign bus.NUMB      = numb_reg;
    assign bus.MASK      = mask_reg;
    assign bus.ERROR     = error_reg;

    // Digit gi is blanked unless it is covered by one of the cnt stored bytes.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_show_mask
            assign show_mask[gi] = (4'(gi) >= {cnt_next, 1'b0});
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        blink_next     = blink_reg;
        banner_restart = 1'b0;

        if (bus.clear) begin
            state_next = IDLE;
            hist_next  = '0;
            cnt_next   = '0;
            hold_next  = '0;
            blink_next = '0;
        end else begin
            if (accept) begin
                hist_next = {hist_reg[23:0], bus.key_data};
                if (cnt_reg != 3'd4) begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end

            if (bus.err_valid) begin
                state_next     = ERR;
                hold_next      = '0;
                blink_next     = '0;
                banner_restart = 1'b1;
            end else begin
                case (state_reg)
                    IDLE, SHOW: begin
                        if (accept) begin
                            state_next = SHOW;
                        end
                    end
                    ERR: begin
                        if (hold_reg == HOLD_LAST) begin
                            state_next = (cnt_reg != 3'd0) ? SHOW : IDLE;
                            hold_next  = '0;
                            blink_next = '0;
                        end else begin
                            hold_next  = hold_reg + 1'b1;
                            blink_next = (blink_reg == BLINK_LAST) ? '0 : blink_reg + 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        numb_next  = 32'h0;
        mask_next  = 8'hFF;
        error_next = 1'b0;
        case (state_next)
            SHOW: begin
                numb_next = hist_next;
                mask_next = show_mask;
            end
            ERR: begin
                numb_next  = 32'hEEEE_EEEE;
                error_next = 1'b1;
                // Blink phase flips each time the blink timer wraps; every (re)entry starts lit.
                if (banner_restart) begin
                    mask_next = 8'h00;
                end else if (blink_reg == BLINK_LAST) begin
                    mask_next = ~mask_reg;
                end else begin
                    mask_next = mask_reg;
                end
            end
            default: begin
                numb_next = 32'h0;
                mask_next = 8'hFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hist_reg  <= '0;
            cnt_reg   <= '0;
            hold_reg  <= '0;
            blink_reg <= '0;
            numb_reg  <= '0;
            mask_reg  <= 8'hFF;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hist_reg  <= hist_next;
            cnt_reg   <= cnt_next;
            hold_reg  <= hold_next;
            blink_reg <= blink_next;
            numb_reg  <= numb_next;
            mask_reg  <= mask_next;
            error_reg <= error_next;
        end
    end

endmodule
